sharpen_pixel_seq: RTL and testbench

// - Sequencer for the image-sharpening extension. Computes one sharpened pixel
//   P = (1+2^CTR_SHIFT)*C - N - S - E - W, clamped to [0, 2^PIX_W-1].
// - Sits directly upstream of the 32-bit add/sub unit: drives its A/B/sub

---
 rtl/sharpen_pixel_seq_if.sv | 28 ++
 rtl/sharpen_pixel_seq.sv | 114 +++++++++++
 tb/tb_sharpen_pixel_seq.sv | 266 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/sharpen_pixel_seq_if.sv
// Request/result handshake and add/sub unit connection for the sharpening sequencer.
interface sharpen_pixel_seq_if #(
    parameter int PIX_W = 8
);
    logic               start;
    logic [PIX_W-1:0]   center;
    logic [4*PIX_W-1:0] nbr;
    logic               busy;
    logic               valid;
    logic [PIX_W-1:0]   pixel;
    logic               err;
    logic [31:0]        as_a;
    logic [31:0]        as_b;
    logic               as_sub;
    logic [31:0]        as_s;
    logic               as_neg;
    logic               as_ovf;

    modport slave (
        input  start, center, nbr, as_s, as_neg, as_ovf,
        output busy, valid, pixel, err, as_a, as_b, as_sub
    );

    modport master (
        output start, center, nbr, as_s, as_neg, as_ovf,
        input  busy, valid, pixel, err, as_a, as_b, as_sub
    );
endinterface

// File: rtl/sharpen_pixel_seq.sv
// Sequences one sharpened pixel (1+2^CTR_SHIFT)*C - N - S - E - W through an
// external 32-bit add/sub unit, one accumulate step per clock, then clamps.
//
// state | meaning
// IDLE  | waiting for start; accumulator holds last result
// OP    | five accumulate steps through the add/sub unit (cnt = step 0..4)
// CLAMP | saturate accumulator into pixel range, pulse valid
module sharpen_pixel_seq #(
    parameter int PIX_W     = 8,
    parameter int CTR_SHIFT = 2
) (
    input logic clk,
    input logic rst_n,
    sharpen_pixel_seq_if.slave bus
);
    typedef enum logic [1:0] {IDLE, OP, CLAMP} state_t;

    localparam logic [31:0] PIX_MAX = (32'd1 << PIX_W) - 32'd1;

    state_t             state, state_nx;
    logic [2:0]         cnt;
    logic [31:0]        acc;
    logic [PIX_W-1:0]   c_q;
    logic [4*PIX_W-1:0] nbr_q;
    logic               err_acc;
    logic               valid;
    logic [PIX_W-1:0]   pixel;
    logic               err;
    logic [31:0]        as_b;
    logic               as_sub;
    logic               unused_sigs;

    // the unit's sign flag is redundant with acc[31] for our value range
    assign unused_sigs = bus.as_neg;

    always_comb begin
        state_nx = state;
        as_b     = '0;
        as_sub   = 1'b0;
        case (state)
            IDLE: begin
                if (bus.start) state_nx = OP;
            end
            OP: begin
                as_sub = (cnt != 3'd0);
                case (cnt)
                    3'd0:    as_b = 32'(c_q) << CTR_SHIFT;
                    3'd1:    as_b = 32'(nbr_q[PIX_W-1:0]);
                    3'd2:    as_b = 32'(nbr_q[2*PIX_W-1:PIX_W]);
                    3'd3:    as_b = 32'(nbr_q[3*PIX_W-1:2*PIX_W]);
                    3'd4:    as_b = 32'(nbr_q[4*PIX_W-1:3*PIX_W]);
                    default: as_b = '0;
                endcase
                if (cnt == 3'd4) state_nx = CLAMP;
            end
            CLAMP: begin
                state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state   <= IDLE;
            cnt     <= '0;
            acc     <= '0;
            c_q     <= '0;
            nbr_q   <= '0;
            err_acc <= 1'b0;
            valid   <= 1'b0;
            pixel   <= '0;
            err     <= 1'b0;
        end else begin
            state <= state_nx;
            valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        c_q     <= bus.center;
                        nbr_q   <= bus.nbr;
                        acc     <= 32'(bus.center);
                        cnt     <= '0;
                        err_acc <= 1'b0;
                    end
                end
                OP: begin
                    acc     <= bus.as_s;
                    err_acc <= err_acc | bus.as_ovf;
                    cnt     <= 3'(cnt + 3'd1);
                end
                CLAMP: begin
                    if (acc[31])
                        pixel <= '0;
                    else if (acc > PIX_MAX)
                        pixel <= PIX_MAX[PIX_W-1:0];
                    else
                        pixel <= acc[PIX_W-1:0];
                    err   <= err_acc;
                    valid <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign bus.busy   = (state != IDLE);
    assign bus.valid  = valid;
    assign bus.pixel  = pixel;
    assign bus.err    = err;
    assign bus.as_a   = acc;
    assign bus.as_b   = as_b;
    assign bus.as_sub = as_sub;
endmodule

// File: tb/tb_sharpen_pixel_seq.sv
// Bench for sharpen_pixel_seq: models the add/sub unit, drives a vector table
// and corner sequences, and checks results through a scoreboard queue.
module tb_sharpen_pixel_seq;
    localparam int PIX_W = 8;

    logic clk = 1'b0;
    logic rst_n;
    logic inj_ovf;
    logic [32:0] add_full;

    always #5 clk = ~clk;

    sharpen_pixel_seq_if #(.PIX_W(PIX_W)) bus();

    sharpen_pixel_seq #(.PIX_W(PIX_W), .CTR_SHIFT(2)) dut (
        .clk(clk),
        .rst_n(rst_n),
        .bus(bus)
    );

    // behavioural 32-bit add/sub unit; inj_ovf fakes an adder overflow
    always_comb begin
        if (bus.as_sub)
            add_full = {bus.as_a[31], bus.as_a} - {bus.as_b[31], bus.as_b};
        else
            add_full = {bus.as_a[31], bus.as_a} + {bus.as_b[31], bus.as_b};
        bus.as_s   = add_full[31:0];
        bus.as_neg = add_full[32];
        bus.as_ovf = (add_full[32] ^ add_full[31]) | inj_ovf;
    end

    typedef struct {
        logic [7:0] pix;
        logic       err;
    } exp_t;

    typedef struct {
        int c, n, s, e, w;
        bit inj;
        int pix;
        bit err;
    } vec_t;

    exp_t sb_q[$];
    vec_t vecs[11];
    int compared   = 0;
    int mismatched = 0;
    int valid_cnt  = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    function automatic int model(input int c, n, s, e, w);
        int p;
        p = 5 * c - n - s - e - w;
        if (p < 0) return 0;
        if (p > 255) return 255;
        return p;
    endfunction

    always @(negedge clk) begin
        exp_t ex;
        if (bus.valid === 1'b1) begin
            valid_cnt++;
            if (sb_q.size() == 0) begin
                compared++;
                mismatched++;
                $display("FAIL unexpected_valid: got pixel %0d, expected no valid", bus.pixel);
            end else begin
                ex = sb_q.pop_front();
                check("pixel", 32'(bus.pixel), 32'(ex.pix));
                check("err", 32'(bus.err), 32'(ex.err));
            end
        end
    end

    task automatic drive_req(input int c, n, s, e, w);
        bus.center = c[7:0];
        bus.nbr    = {w[7:0], e[7:0], s[7:0], n[7:0]};
        bus.start  = 1'b1;
    endtask

    task automatic release_req();
        #1;
        bus.start  = 1'b0;
        bus.center = 8'($urandom);
        bus.nbr    = $urandom;
    endtask

    // waits for valid after e0; returns cycles counted (negedges since e0)
    task automatic wait_valid(input string tag, output int cyc);
        cyc = 0;
        do begin
            @(negedge clk);
            cyc++;
            if (cyc == 3) check({tag, "_busy_mid"}, 32'(bus.busy), 32'd1);
        end while (bus.valid !== 1'b1 && cyc < 20);
        if (bus.valid !== 1'b1) begin
            compared++;
            mismatched++;
            $display("FAIL %s_timeout: got no valid in %0d cycles, expected 7", tag, cyc);
        end else begin
            check({tag, "_latency"}, 32'(cyc), 32'd7);
            check({tag, "_busy_end"}, 32'(bus.busy), 32'd0);
        end
    endtask

    task automatic run_pixel(input int c, n, s, e, w, input bit inj, input int pix, input bit err);
        int cyc;
        @(negedge clk);
        drive_req(c, n, s, e, w);
        inj_ovf = inj;
        sb_q.push_back(exp_t'{pix[7:0], err});
        @(posedge clk);
        release_req();
        wait_valid("run", cyc);
        inj_ovf = 1'b0;
    endtask

    initial begin
        #300000;
        mismatched++;
        $display("FAIL watchdog: got no finish, expected finish before time limit");
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $fatal(1, "watchdog");
    end

    initial begin
        int cyc;
        int vc;
        int rc, rn, rs, re, rw;
        logic [7:0] last_pix;

        vecs[0]  = '{100, 100, 100, 100, 100, 0, 100, 0};
        vecs[1]  = '{255,   0,   0,   0,   0, 0, 255, 0};
        vecs[2]  = '{  0, 255, 255, 255, 255, 0,   0, 0};
        vecs[3]  = '{ 60,  10,  20,  30,  40, 0, 200, 0};
        vecs[4]  = '{ 51,   0,   0,   0,   0, 0, 255, 0};
        vecs[5]  = '{ 52,   0,   0,   0,   0, 0, 255, 0};
        vecs[6]  = '{ 50,   0,   0,   0,   0, 0, 250, 0};
        vecs[7]  = '{ 10,  49,   0,   0,   0, 0,   1, 0};
        vecs[8]  = '{ 10,  50,   1,   0,   0, 0,   0, 0};
        vecs[9]  = '{ 20,  25,  25,  25,  25, 0,   0, 0};
        vecs[10] = '{100, 100, 100, 100, 100, 1, 100, 1};

        rst_n      = 1'b0;
        inj_ovf    = 1'b0;
        bus.start  = 1'b0;
        bus.center = '0;
        bus.nbr    = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_busy", 32'(bus.busy), 32'd0);
        check("rst_valid", 32'(bus.valid), 32'd0);
        check("rst_pixel", 32'(bus.pixel), 32'd0);
        check("rst_err", 32'(bus.err), 32'd0);
        check("rst_as_a", bus.as_a, 32'd0);
        rst_n = 1'b1;

        foreach (vecs[i])
            run_pixel(vecs[i].c, vecs[i].n, vecs[i].s, vecs[i].e, vecs[i].w,
                      vecs[i].inj, vecs[i].pix, vecs[i].err);

        for (int i = 0; i < 6; i++) begin
            rc = $urandom_range(0, 255);
            rn = $urandom_range(0, 255);
            rs = $urandom_range(0, 255);
            re = $urandom_range(0, 255);
            rw = $urandom_range(0, 255);
            run_pixel(rc, rn, rs, re, rw, 1'b0, model(rc, rn, rs, re, rw), 1'b0);
        end

        // per-step operand check
        @(negedge clk);
        drive_req(60, 10, 20, 30, 40);
        sb_q.push_back(exp_t'{8'd200, 1'b0});
        @(posedge clk);
        release_req();
        begin
            int exp_b[5] = '{240, 10, 20, 30, 40};
            for (int k = 0; k < 5; k++) begin
                @(negedge clk);
                check($sformatf("step%0d_as_b", k), bus.as_b, 32'(exp_b[k]));
                check($sformatf("step%0d_as_sub", k), 32'(bus.as_sub), (k == 0) ? 32'd0 : 32'd1);
                if (k == 0) check("step0_as_a", bus.as_a, 32'd60);
            end
        end
        @(negedge clk);
        check("clamp_as_b", bus.as_b, 32'd0);
        check("clamp_as_sub", 32'(bus.as_sub), 32'd0);
        @(negedge clk);
        check("step_seq_valid", 32'(bus.valid), 32'd1);
        @(negedge clk);
        check("valid_clears", 32'(bus.valid), 32'd0);
        check("idle_as_b", bus.as_b, 32'd0);
        check("pixel_holds", 32'(bus.pixel), 32'd200);

        // start while busy is ignored
        vc = valid_cnt;
        @(negedge clk);
        drive_req(30, 5, 5, 5, 5);
        sb_q.push_back(exp_t'{8'd130, 1'b0});
        @(posedge clk);
        release_req();
        @(negedge clk);
        @(negedge clk);
        bus.start = 1'b1;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        repeat (20) @(negedge clk);
        check("ignored_start_valids", 32'(valid_cnt - vc), 32'd1);
        check("ignored_start_queue", 32'(sb_q.size()), 32'd0);

        // back-to-back: start held in the valid cycle
        @(negedge clk);
        drive_req(40, 0, 0, 0, 10);
        sb_q.push_back(exp_t'{8'd190, 1'b0});
        @(posedge clk);
        release_req();
        wait_valid("b2b_first", cyc);
        drive_req(70, 20, 20, 20, 20);
        sb_q.push_back(exp_t'{8'd255, 1'b0});
        @(posedge clk);
        release_req();
        wait_valid("b2b_second", cyc);
        last_pix = bus.pixel;
        @(negedge clk);
        check("b2b_pixel_nonzero", 32'(last_pix != 8'd0), 32'd1);

        // reset mid-operation aborts without valid
        vc = valid_cnt;
        drive_req(90, 1, 2, 3, 4);
        @(posedge clk);
        release_req();
        @(negedge clk);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(negedge clk);
        check("midrst_busy", 32'(bus.busy), 32'd0);
        check("midrst_valid", 32'(bus.valid), 32'd0);
        check("midrst_pixel", 32'(bus.pixel), 32'd0);
        check("midrst_err", 32'(bus.err), 32'd0);
        check("midrst_as_a", bus.as_a, 32'd0);
        repeat (12) @(negedge clk);
        check("midrst_no_valid", 32'(valid_cnt - vc), 32'd0);

        run_pixel(80, 30, 30, 30, 30, 1'b0, 255, 1'b0);
        run_pixel(45, 50, 40, 30, 20, 1'b0, 85, 1'b0);

        repeat (3) @(negedge clk);
        check("queue_drained", 32'(sb_q.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
